// File: rtl/conv_seq_ctrl.sv
// Sequencer for the weight-stationary conv systolic array: kernel preload, pixel-index streaming, drain/timeout.
// Latency start->done: 1 + IF_PORT + 1 + 1 + IF_WIDTH*IF_HEIGHT + drain cycles + 1; outputs are state-decoded.
// Backpressure: if_ready=0 holds if_req and if_pix_idx stable; only the pixel counter waits, no other stage stalls.
module conv_seq_ctrl #(
  parameter int IF_WIDTH      = 128,
  parameter int IF_HEIGHT     = 128,
  parameter int IF_PORT       = 27,
  parameter int K_NUM         = 3,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err_timeout,
  output logic                                   k_rd_en,
  output logic [$clog2(IF_PORT)-1:0]             k_rd_addr,
  output logic                                   k_prefetch,
  output logic [K_NUM-1:0]                       k_valid,
  output logic                                   if_start,
  input  logic                                   if_ready,
  output logic                                   if_req,
  output logic [$clog2(IF_WIDTH*IF_HEIGHT)-1:0]  if_pix_idx,
  input  logic                                   of_done
);

  localparam int KAW = $clog2(IF_PORT);
  localparam int PAW = $clog2(IF_WIDTH*IF_HEIGHT);
  localparam int TAW = $clog2(DRAIN_TIMEOUT);

  localparam logic [KAW-1:0] K_LAST   = KAW'(IF_PORT - 1);
  localparam logic [PAW-1:0] PIX_LAST = PAW'(IF_WIDTH*IF_HEIGHT - 1);
  localparam logic [TAW-1:0] T_LAST   = TAW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_K_LOAD,
    S_K_FLUSH,
    S_IF_START,
    S_IF_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [KAW-1:0]  k_cnt_q, k_cnt_d;
  logic [PAW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [TAW-1:0]  t_cnt_q, t_cnt_d;
  logic            err_q, err_d;
  logic            kvld_q;

  // Kernel data arrives one cycle after the read, so prefetch/valid are the delayed read enable.
  assign k_prefetch  = kvld_q;
  assign k_valid     = {K_NUM{kvld_q}};
  assign err_timeout = err_q;

  // Next-state, counter updates and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    k_cnt_d    = k_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    t_cnt_d    = t_cnt_q;
    err_d      = err_q;
    busy       = 1'b1;
    done       = 1'b0;
    k_rd_en    = 1'b0;
    k_rd_addr  = '0;
    if_start   = 1'b0;
    if_req     = 1'b0;
    if_pix_idx = '0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // A new run clears the sticky timeout flag and every counter.
        if (start) begin
          state_d   = S_K_LOAD;
          k_cnt_d   = '0;
          pix_cnt_d = '0;
          t_cnt_d   = '0;
          err_d     = 1'b0;
        end
      end

      S_K_LOAD: begin
        k_rd_en   = 1'b1;
        k_rd_addr = k_cnt_q;
        if (k_cnt_q == K_LAST) begin
          k_cnt_d = '0;
          state_d = S_K_FLUSH;
        end else begin
          k_cnt_d = k_cnt_q + KAW'(1);
        end
      end

      // Last kernel word is on the bus this cycle; nothing else to do.
      S_K_FLUSH: state_d = S_IF_START;

      S_IF_START: begin
        if_start = 1'b1;
        state_d  = S_IF_STREAM;
      end

      S_IF_STREAM: begin
        if_req     = 1'b1;
        if_pix_idx = pix_cnt_q;
        if (if_ready) begin
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + PAW'(1);
          end
        end
      end

      // Completion wins over timeout when both land on the final drain cycle.
      S_DRAIN: begin
        if (of_done) begin
          state_d = S_DONE;
        end else if (t_cnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          t_cnt_d = t_cnt_q + TAW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; reset also squashes any kernel valid in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_cnt_q   <= '0;
      pix_cnt_q <= '0;
      t_cnt_q   <= '0;
      err_q     <= 1'b0;
      kvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_cnt_q   <= k_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      t_cnt_q   <= t_cnt_d;
      err_q     <= err_d;
      kvld_q    <= k_rd_en;
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: run-position reference model plus literal checks.
module tb_conv_seq_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int P  = 3;
  localparam int KN = 3;
  localparam int DT = 16;
  localparam int N  = W*H;

  logic clk = 1'b0;
  logic rst, start, if_ready, of_done;
  logic busy, done, err_timeout, k_rd_en, k_prefetch, if_start, if_req;
  logic [$clog2(P)-1:0] k_rd_addr;
  logic [KN-1:0]        k_valid;
  logic [$clog2(N)-1:0] if_pix_idx;

  always #5 clk = ~clk;

  conv_seq_ctrl #(
    .IF_WIDTH(W), .IF_HEIGHT(H), .IF_PORT(P), .K_NUM(KN), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .k_rd_en(k_rd_en), .k_rd_addr(k_rd_addr),
    .k_prefetch(k_prefetch), .k_valid(k_valid), .if_start(if_start),
    .if_ready(if_ready), .if_req(if_req), .if_pix_idx(if_pix_idx), .of_done(of_done)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference model: position within a run, in plain counts.
  // m_pre: cycles since start was accepted (0..P-1 kernel read, P flush, P+1 if_start, P+2 streaming)
  bit m_run = 0, m_done_now = 0, m_err = 0, m_prev_ken = 0;
  int m_pre = 0, m_xf = 0, m_dr = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        ken;
    logic        ifs;
    logic        req;
    logic [31:0] addr;
    logic [31:0] idx;
  } exp_t;

  function automatic exp_t calc_exp();
    exp_t e;
    e = '0;
    if (m_run) begin
      e.busy = 1'b1;
      if (m_done_now) e.done = 1'b1;
      else if (m_pre < P) begin e.ken = 1'b1; e.addr = 32'(m_pre); end
      else if (m_pre == P+1) e.ifs = 1'b1;
      else if (m_pre == P+2 && m_xf < N) begin e.req = 1'b1; e.idx = 32'(m_xf); end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = calc_exp();
    if (rst) begin
      m_run = 0; m_done_now = 0; m_err = 0; m_prev_ken = 0;
      m_pre = 0; m_xf = 0; m_dr = 0;
    end else begin
      m_prev_ken = e.ken;
      if (!m_run) begin
        if (start) begin m_run = 1; m_pre = 0; m_xf = 0; m_dr = 0; m_err = 0; end
      end else if (m_done_now) begin
        m_run = 0; m_done_now = 0;
      end else if (m_pre < P+2) begin
        m_pre++;
      end else if (m_xf < N) begin
        if (if_ready) m_xf++;
      end else if (of_done) begin
        m_done_now = 1;
      end else if (m_dr == DT-1) begin
        m_err = 1; m_run = 0;
      end else begin
        m_dr++;
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = calc_exp();
      chk("busy",        32'(busy),        32'(e.busy));
      chk("done",        32'(done),        32'(e.done));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
      chk("k_rd_en",     32'(k_rd_en),     32'(e.ken));
      chk("k_rd_addr",   32'(k_rd_addr),   e.addr);
      chk("k_prefetch",  32'(k_prefetch),  32'(m_prev_ken));
      chk("k_valid",     32'(k_valid),     m_prev_ken ? 32'h7 : 32'h0);
      chk("if_start",    32'(if_start),    32'(e.ifs));
      chk("if_req",      32'(if_req),      32'(e.req));
      chk("if_pix_idx",  32'(if_pix_idx),  e.idx);
    end
  end

  // Observations of the DUT for literal end-of-run checks.
  logic [$clog2(N)-1:0] xq[$];
  logic [$clog2(P)-1:0] kq[$];
  int done_cnt = 0, ifs_cnt = 0, busy_cyc = 0, pf_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (if_req && if_ready) xq.push_back(if_pix_idx);
      if (k_rd_en)    kq.push_back(k_rd_addr);
      if (done)       done_cnt++;
      if (if_start)   ifs_cnt++;
      if (busy)       busy_cyc++;
      if (k_prefetch) pf_cnt++;
    end
  end

  task automatic clr_obs();
    xq.delete(); kq.delete();
    done_cnt = 0; ifs_cnt = 0; busy_cyc = 0; pf_cnt = 0;
  endtask

  int rdy_mode = 0;
  int pc = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: if_ready = 1'b1;
      1: begin if_ready = ((pc % 4) == 0) || ((pc % 4) == 3); pc++; end
      default: if_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_xfers();
    chk("xfer_count", 32'(xq.size()), 32'(N));
    for (int i = 0; i < xq.size() && i < N; i++) chk("xfer_idx", 32'(xq[i]), 32'(i));
  endtask

  task automatic check_kaddr();
    chk("k_addr_count", 32'(kq.size()), 32'(P));
    for (int i = 0; i < kq.size() && i < P; i++) chk("k_addr", 32'(kq[i]), 32'(i));
  endtask

  // One complete run; dly = drain cycle holding of_done (0 = never).
  task automatic run_one(input int rmode, input int dly, input bit early, input bit bstart);
    bit early_done;
    int guard;
    early_done = 0;
    guard = 0;
    rdy_mode = rmode;
    pc = 0;
    clr_obs();
    start = 1'b1; step(); start = 1'b0;
    chk("err_clear_on_start", 32'(err_timeout), 32'd0);
    while (!(m_run && m_pre == P+2 && m_xf == N) && guard < 400) begin
      if (early && !early_done && m_pre == P+2 && m_xf == 7) begin of_done = 1'b1; early_done = 1; end
      if (bstart && m_pre == P+2 && m_xf == 5) start = 1'b1;
      step(); of_done = 1'b0; start = 1'b0;
      guard++;
    end
    if (guard >= 400) fail_bound("stream_bound");
    if (dly > 0) begin
      for (int i = 0; i < dly-1; i++) begin
        if (bstart && i == 1) start = 1'b1;
        step(); start = 1'b0;
      end
      of_done = 1'b1; step(); of_done = 1'b0;
    end
    guard = 0;
    while (m_run && guard < 40) begin step(); guard++; end
    if (guard >= 40) fail_bound("idle_bound");
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; if_ready = 1'b0; of_done = 1'b0;
    step();
    chk_en = 1;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_busy",    32'(busy),        32'd0);
    chk("reset_err",     32'(err_timeout), 32'd0);
    chk("reset_k_rd_en", 32'(k_rd_en),     32'd0);
    chk("reset_if_req",  32'(if_req),      32'd0);

    // Nominal: full ready, of_done in the 5th drain cycle.
    run_one(0, 5, 0, 0);
    check_xfers(); check_kaddr();
    chk("nom_done_cnt", 32'(done_cnt), 32'd1);
    chk("nom_ifs_cnt",  32'(ifs_cnt),  32'd1);
    chk("nom_pf_cnt",   32'(pf_cnt),   32'd3);
    chk("nom_busy_cyc", 32'(busy_cyc), 32'd27);

    // Backpressure 1,0,0,1 pattern.
    run_one(1, 3, 0, 0);
    check_xfers();
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Timeout: of_done never arrives.
    run_one(0, 0, 0, 0);
    chk("to_err",      32'(err_timeout), 32'd1);
    chk("to_done_cnt", 32'(done_cnt),    32'd0);
    chk("to_busy_cyc", 32'(busy_cyc),    32'd37);

    // Start while busy (stream and drain); also clears the timeout flag on accept.
    run_one(0, 6, 0, 1);
    check_xfers(); check_kaddr();
    chk("sb_done_cnt", 32'(done_cnt), 32'd1);
    chk("sb_ifs_cnt",  32'(ifs_cnt),  32'd1);

    // Reset in the cycle presenting kernel address 1.
    rdy_mode = 0;
    clr_obs();
    start = 1'b1; step(); start = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_k_rd_en",    32'(k_rd_en),    32'd0);
    chk("rst_k_prefetch", 32'(k_prefetch), 32'd0);
    chk("rst_k_valid",    32'(k_valid),    32'd0);
    chk("rst_k_addr",     32'(k_rd_addr),  32'd0);
    chk("rst_kq_seen",    32'(kq.size()),  32'd2);
    run_one(0, 5, 0, 0);
    check_xfers(); check_kaddr();
    chk("rst_done_cnt", 32'(done_cnt), 32'd1);
    chk("rst_busy_cyc", 32'(busy_cyc), 32'd27);

    // Early of_done at index 7 is ignored.
    run_one(1, 8, 1, 0);
    check_xfers();
    chk("early_done_cnt", 32'(done_cnt), 32'd1);

    // Drain boundary: of_done on the last allowed cycle, then one cycle too late.
    run_one(0, 16, 0, 0);
    chk("edge16_done_cnt", 32'(done_cnt),    32'd1);
    chk("edge16_err",      32'(err_timeout), 32'd0);
    run_one(0, 17, 0, 0);
    chk("edge17_done_cnt", 32'(done_cnt),    32'd0);
    chk("edge17_err",      32'(err_timeout), 32'd1);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      run_one(2, int'($urandom_range(1, 18)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_xfers();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
